// File: rtl/btn_arb_pkg.sv
// ============================================================================
// btn_arb_pkg : shared widths, accept-stage classification for button_event_arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package btn_arb_pkg;

    // Outcome of one button's pulse at a clock edge
    typedef enum logic [1:0] {
        ACC_NONE   = 2'd0,
        ACC_BOUNCE = 2'd1,
        ACC_NEW    = 2'd2,
        ACC_DROP   = 2'd3
    } acc_e;

    function automatic int btn_id_w(input int n_btn);
        return (n_btn < 2) ? 1 : $clog2(n_btn);
    endfunction

    function automatic int lockout_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic acc_e classify(input logic pulse, input logic locked, input logic pend);
        if (!pulse) begin
            return ACC_NONE;
        end else if (locked) begin
            return ACC_BOUNCE;
        end else if (pend) begin
            return ACC_DROP;
        end else begin
            return ACC_NEW;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick of the first request at or after ptr
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = btn_id_w(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any_grant
);

    always_comb begin
        int             sum;
        logic [IDW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = 0;
        idx       = '0;
        // Scan N slots starting at ptr, wrapping modulo N (N need not be a power of two)
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = IDW'(sum);
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_event_arbiter.sv
// ============================================================================
// button_event_arbiter : lockout-filtered button pulses, round-robin queued to one consumer
// Revision             : 1.0
// ============================================================================
`default_nettype none

module button_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_BTN-1:0]           btn_pulse,
    input  logic                       evt_ready,
    output logic                       evt_valid,
    output logic [btn_id_w(N_BTN)-1:0] evt_id,
    input  logic                       ovf_clr,
    output logic                       overflow
);

    localparam int ID_W  = btn_id_w(N_BTN);
    localparam int LK_W  = lockout_w(LOCKOUT_CYCLES);
    localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [LK_W-1:0]  LOCKOUT_LOAD = LK_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(N_BTN - 1);

    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] set_pend;
    logic [N_BTN-1:0] drop;
    logic [N_BTN-1:0] reload;
    logic [LK_W-1:0]  lockout [N_BTN];

    logic [N_BTN-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             any_grant;
    logic [ID_W-1:0]  rr_ptr;

    logic [ID_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full;
    logic             push;
    logic             pop;

    // Accept stage: decisions use pre-edge lockout and pending values
    always_comb begin
        acc_e acc;
        acc      = ACC_NONE;
        set_pend = '0;
        drop     = '0;
        reload   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            acc = classify(btn_pulse[i], lockout[i] != '0, pending[i]);
            set_pend[i] = (acc == ACC_NEW);
            drop[i]     = (acc == ACC_DROP);
            reload[i]   = (acc == ACC_NEW) || (acc == ACC_DROP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                lockout[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (reload[i]) begin
                    lockout[i] <= LOCKOUT_LOAD;
                end else if (lockout[i] != '0) begin
                    lockout[i] <= lockout[i] - 1'b1;
                end
            end
        end
    end

    rr_arbiter #(
        .N   (N_BTN),
        .IDW (ID_W)
    ) u_rr_arbiter (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign push = any_grant && !full;
    assign pop  = evt_valid && evt_ready;

    // A granted bit clears; a fresh acceptance on the same edge can only set it again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            rr_ptr  <= '0;
        end else begin
            pending <= (pending & ~(push ? grant : '0)) | set_pend;
            if (push) begin
                rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

    // full and evt_valid are registered copies of the next occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            evt_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            full      <= (count_next == DEPTH_CNT);
            evt_valid <= (count_next != '0);
        end
    end

    assign evt_id = evt_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
// ============================================================================
// tb_button_event_arbiter : directed and random stimulus against a queue-based model
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_button_event_arbiter;

    localparam int N     = 4;
    localparam int LOCK  = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_pulse;
    logic         evt_ready;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic         ovf_clr;
    logic         overflow;

    button_event_arbiter #(
        .N_BTN          (N),
        .LOCKOUT_CYCLES (LOCK),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: lockout remaining, waiting presses, delivered-event queue
    int m_lock [N];
    bit m_pend [N];
    int m_q [$];
    int m_ptr;
    bit m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_lock[i] = 0;
            m_pend[i] = 1'b0;
        end
        m_q.delete();
        m_ptr = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] p, input logic r, input logic c);
        bit was_full;
        bit newp [N];
        bit lost;
        int g;
        was_full = (m_q.size() == DEPTH);
        lost     = 1'b0;
        g        = -1;
        for (int i = 0; i < N; i++) begin
            newp[i] = 1'b0;
            if (p[i] && m_lock[i] == 0) begin
                if (m_pend[i]) lost = 1'b1;
                else newp[i] = 1'b1;
                m_lock[i] = LOCK;
            end else if (m_lock[i] > 0) begin
                m_lock[i] = m_lock[i] - 1;
            end
        end
        if (!was_full) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (m_q.size() > 0 && r) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (newp[i]) m_pend[i] = 1'b1;
        end
        if (lost) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endfunction

    // Called just after a falling edge: compare, drive, clock, advance model
    task automatic step(input logic [N-1:0] p, input logic r, input logic c);
        check("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("evt_id", 32'(evt_id), 32'(m_q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        btn_pulse = p;
        evt_ready = r;
        ovf_clr   = c;
        @(posedge clk);
        model_step(p, r, c);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step('0, r, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        btn_pulse = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] p;
        logic         r;
        logic         c;
        int           pden;
        int           rpct;

        rst       = 1'b1;
        btn_pulse = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("init_valid", 32'(evt_valid), 32'd0);
        check("init_id", 32'(evt_id), 32'd0);
        check("init_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Single press
        step(4'b0001, 1'b1, 1'b0);
        idle(4, 1'b1);
        // Bounce on button 2 at relative cycles 0, 3, 9
        for (int t = 0; t < 24; t++) step((t == 0 || t == 3 || t == 9) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
        // Simultaneous presses twice, second after lockout
        for (int k = 0; k < 2; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            idle(LOCK + 4, 1'b1);
        end
        // Backpressure: FIFO fills, button 0 waits pending
        step(4'b1111, 1'b0, 1'b0);
        idle(LOCK + 2, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        idle(6, 1'b0);
        idle(10, 1'b1);
        idle(LOCK, 1'b1);
        // Overflow: second press of pending button 1 while FIFO is full
        step(4'b1111, 1'b0, 1'b0);
        idle(LOCK + 2, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        idle(LOCK + 2, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);
        step('0, 1'b1, 1'b1);
        idle(LOCK + 2, 1'b1);
        // Set and clear in the same cycle: set wins
        step(4'b1111, 1'b0, 1'b0);
        idle(LOCK + 2, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        idle(LOCK + 2, 1'b0);
        step(4'b0100, 1'b0, 1'b1);
        idle(2, 1'b0);
        // Async reset mid-drain with three queued
        step('0, 1'b1, 1'b0);
        async_reset();
        idle(LOCK + 4, 1'b1);

        // Random phases with varying press density and backpressure
        for (int seg = 0; seg < 20; seg++) begin
            pden = $urandom_range(2, 24);
            rpct = (seg % 5 == 0) ? 0 : $urandom_range(10, 100);
            for (int t = 0; t < 150; t++) begin
                for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, pden - 1) == 0);
                r = ($urandom_range(0, 99) < rpct);
                c = ($urandom_range(0, 15) == 0);
                step(p, r, c);
            end
            if (seg == 11) async_reset();
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
